// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the sprite line drawer: FSM state encoding, the
// field positions inside the 32-bit sprite row descriptor, default widths and
// the reserved background colour address.
// -----------------------------------------------------------------------------
package draw_pkg;

    // Default widths of the sprite memory address and the pixel-count field
    localparam int SIZE_ADDRESS = 14;
    localparam int SIZE_WIDTH   = 5;

    // Reserved background colour address; the drawer never emits it
    localparam logic [SIZE_ADDRESS-1:0] ADDRESS_BG = 14'd16383;

    // Descriptor field positions inside sprite_datas
    localparam int BASE_MSB = 27;
    localparam int BASE_LSB = 14;
    localparam int CNT_MSB  = 4;
    localparam int CNT_LSB  = 0;

    // Row drawer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } draw_state_e;

endpackage : draw_pkg

// File: rtl/sprite_addr_gen.sv
// -----------------------------------------------------------------------------
// sprite_addr_gen
// Combinational sprite memory address generator: base + idx, wrapped modulo
// 2^SIZE_ADDRESS. The background colour address is reserved, so a sum landing
// on it is pulled down by one (saturating clamp). The parent registers the
// result.
//
// Ports:
//   base  in  SIZE_ADDRESS  row base address
//   idx   in  SIZE_WIDTH    pixel index within the row
//   addr  out SIZE_ADDRESS  clamped sprite memory address
// -----------------------------------------------------------------------------
module sprite_addr_gen
    import draw_pkg::*;
#(
    parameter int                      SIZE_ADDRESS_P = SIZE_ADDRESS,
    parameter int                      SIZE_WIDTH_P   = SIZE_WIDTH,
    parameter logic [SIZE_ADDRESS_P-1:0] ADDRESS_BG_P = ADDRESS_BG
) (
    input  logic [SIZE_ADDRESS_P-1:0] base,
    input  logic [SIZE_WIDTH_P-1:0]   idx,
    output logic [SIZE_ADDRESS_P-1:0] addr
);

    localparam logic [SIZE_ADDRESS_P-1:0] ADDR_ONE = {{(SIZE_ADDRESS_P-1){1'b0}}, 1'b1};

    logic [SIZE_ADDRESS_P-1:0] sum_s;

    // Wrapping add followed by the background-address clamp
    always_comb begin
        sum_s = base + {{(SIZE_ADDRESS_P-SIZE_WIDTH_P){1'b0}}, idx};
        if (sum_s == ADDRESS_BG_P) begin
            addr = ADDRESS_BG_P - ADDR_ONE;
        end else begin
            addr = sum_s;
        end
    end

endmodule : sprite_addr_gen

// File: rtl/sprite_line_drawer.sv
// -----------------------------------------------------------------------------
// sprite_line_drawer
// Consumer side of the sprite_on / sprite_datas / count_finished handshake.
// On sprite_on the row descriptor is latched, then one sprite memory address
// is issued per accepted pixel strobe until the row is complete or clipped by
// the end of the active area. count_finished then pulses for one cycle and the
// block waits for the controller to drop sprite_on before re-arming.
//
// Ports:
//   clk             in   system clock
//   reset           in   asynchronous reset, active low
//   sprite_on       in   row draw request, held until the controller leaves
//   sprite_datas    in   [27:14] row base address, [4:0] pixel count - 1
//   pixel_en        in   one-clk pixel strobe
//   active_area     in   monitor active-area flag
//   memory_address  out  sprite memory address of the current pixel
//   addr_valid      out  memory_address is valid this cycle
//   count_finished  out  one-cycle pulse: row complete or clipped
//   busy            out  high in LOAD, DRAW and DONE
// -----------------------------------------------------------------------------
module sprite_line_drawer
    import draw_pkg::*;
#(
    parameter int                      size_address = SIZE_ADDRESS,
    parameter int                      size_width   = SIZE_WIDTH,
    parameter logic [size_address-1:0] address_BG   = ADDRESS_BG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sprite_on,
    input  logic [31:0]             sprite_datas,
    input  logic                    pixel_en,
    input  logic                    active_area,
    output logic [size_address-1:0] memory_address,
    output logic                    addr_valid,
    output logic                    count_finished,
    output logic                    busy
);

    localparam logic [size_width-1:0] IDX_ONE = {{(size_width-1){1'b0}}, 1'b1};

    draw_state_e             state_q,  state_d;
    logic [size_address-1:0] base_q,   base_d;
    logic [size_width-1:0]   last_q,   last_d;
    logic [size_width-1:0]   idx_q,    idx_d;
    logic [size_address-1:0] addr_q,   addr_d;
    logic                    valid_q,  valid_d;
    logic                    cf_q,     cf_d;
    logic                    busy_q,   busy_d;
    logic [size_address-1:0] gen_addr_s;

    // Descriptor bits outside the two fields carry nothing for this block
    logic unused_desc_bits_s;
    assign unused_desc_bits_s = ^{sprite_datas[31:BASE_MSB+1], sprite_datas[BASE_LSB-1:CNT_MSB+1]};

    // Address of the current pixel; idx is 0 while in LOAD so this yields base
    sprite_addr_gen #(
        .SIZE_ADDRESS_P (size_address),
        .SIZE_WIDTH_P   (size_width),
        .ADDRESS_BG_P   (address_BG)
    ) u_addr_gen (
        .base (base_q),
        .idx  (idx_q),
        .addr (gen_addr_s)
    );

    // Next-state and next-output logic for the row drawer
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        last_d  = last_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        cf_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sprite_on) begin
                    state_d = ST_LOAD;
                    base_d  = sprite_datas[BASE_MSB:BASE_LSB];
                    last_d  = sprite_datas[CNT_MSB:CNT_LSB];
                    idx_d   = {size_width{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD, ST_DRAW: begin
                // Abort wins over a coincident pixel strobe: no address, no pulse
                if (!sprite_on) begin
                    state_d = ST_IDLE;
                end else if (pixel_en) begin
                    if (active_area) begin
                        addr_d  = gen_addr_s;
                        valid_d = 1'b1;
                        idx_d   = idx_q + IDX_ONE;
                        // Completion pulse rides along with the last address
                        if (idx_q == last_q) begin
                            cf_d    = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DRAW;
                        end
                    end else begin
                        // Clipped by the end of the active area
                        cf_d    = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                // Controller still holds sprite_on for a clk after the pulse;
                // re-arm only once it has been released
                if (!sprite_on) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            base_q  <= {size_address{1'b0}};
            last_q  <= {size_width{1'b0}};
            idx_q   <= {size_width{1'b0}};
            addr_q  <= {size_address{1'b0}};
            valid_q <= 1'b0;
            cf_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            cf_q    <= cf_d;
            busy_q  <= busy_d;
        end
    end

    assign memory_address = addr_q;
    assign addr_valid     = valid_q;
    assign count_finished = cf_q;
    assign busy           = busy_q;

endmodule : sprite_line_drawer

// File: tb/tb_sprite_line_drawer.sv
// -----------------------------------------------------------------------------
// tb_sprite_line_drawer
// Directed bench for sprite_line_drawer: nominal row, 1-pixel row, clip in
// LOAD and DRAW, address wrap with background clamp, abort, asynchronous reset
// mid-row and a back-to-back request. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_sprite_line_drawer;

    logic        clk;
    logic        reset;
    logic        sprite_on;
    logic [31:0] sprite_datas;
    logic        pixel_en;
    logic        active_area;
    logic [13:0] memory_address;
    logic        addr_valid;
    logic        count_finished;
    logic        busy;

    int checks;
    int failures;

    sprite_line_drawer dut (
        .clk            (clk),
        .reset          (reset),
        .sprite_on      (sprite_on),
        .sprite_datas   (sprite_datas),
        .pixel_en       (pixel_en),
        .active_area    (active_area),
        .memory_address (memory_address),
        .addr_valid     (addr_valid),
        .count_finished (count_finished),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Descriptor with junk in the ignored bits
    function automatic logic [31:0] desc(input logic [13:0] b, input logic [4:0] c);
        return {4'hA, b, 9'h1FF, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [13:0] a, input logic v, input logic cf);
        checks++;
        assert (memory_address === a) else begin
            failures++;
            $error("FAIL %s.addr observed=0x%0h expected=0x%0h", tag, memory_address, a);
        end
        chk_bit({tag, ".valid"}, addr_valid, v);
        chk_bit({tag, ".cf"}, count_finished, cf);
    endtask

    // One pixel strobe; results are visible after the edge that accepts it
    task automatic pixel(input logic aa);
        pixel_en    = 1'b1;
        active_area = aa;
        tick();
        pixel_en    = 1'b0;
    endtask

    initial begin
        logic [13:0] wrap_exp [8];
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        sprite_on    = 1'b0;
        sprite_datas = 32'h0;
        pixel_en     = 1'b0;
        active_area  = 1'b0;
        wrap_exp     = '{14'h3FFA, 14'h3FFB, 14'h3FFC, 14'h3FFD,
                         14'h3FFE, 14'h3FFE, 14'h0000, 14'h0001};

        // Reset state
        tick();
        tick();
        chk_out("reset", 14'h0000, 1'b0, 1'b0);
        chk_bit("reset.busy", busy, 1'b0);
        reset = 1'b1;
        tick();

        // pixel_en in IDLE is ignored
        pixel(1'b1);
        chk_out("idle_pix", 14'h0000, 1'b0, 1'b0);
        chk_bit("idle_pix.busy", busy, 1'b0);

        // Nominal row: base 0x0100, 20 pixels, strobe every 2 clks
        sprite_datas = desc(14'h0100, 5'd19);
        sprite_on    = 1'b1;
        tick();
        chk_bit("nom_load.busy", busy, 1'b1);
        chk_out("nom_load", 14'h0000, 1'b0, 1'b0);
        sprite_datas = desc(14'h2AAA, 5'd3);   // must be ignored now
        for (int i = 0; i < 20; i++) begin
            pixel(1'b1);
            chk_out("nom_pix", 14'(14'h0100 + i), 1'b1, (i == 19));
            tick();
            chk_out("nom_gap", 14'(14'h0100 + i), 1'b0, 1'b0);
        end
        chk_bit("nom_done.busy", busy, 1'b1);
        pixel(1'b1);
        chk_out("nom_done_pix", 14'h0113, 1'b0, 1'b0);
        sprite_on = 1'b0;
        tick();
        chk_bit("nom_idle.busy", busy, 1'b0);

        // 1-pixel row
        sprite_datas = desc(14'h0200, 5'd0);
        sprite_on    = 1'b1;
        tick();
        pixel(1'b1);
        chk_out("one_pix", 14'h0200, 1'b1, 1'b1);
        tick();
        chk_out("one_after", 14'h0200, 1'b0, 1'b0);
        tick();
        chk_bit("one_done.busy", busy, 1'b1);
        pixel(1'b1);
        chk_out("one_done_pix", 14'h0200, 1'b0, 1'b0);
        sprite_on = 1'b0;
        tick();
        chk_bit("one_idle.busy", busy, 1'b0);

        // Clip on the very first strobe (in LOAD)
        sprite_datas = desc(14'h0300, 5'd5);
        sprite_on    = 1'b1;
        tick();
        pixel(1'b0);
        chk_out("loadclip", 14'h0200, 1'b0, 1'b1);
        tick();
        chk_out("loadclip_after", 14'h0200, 1'b0, 1'b0);
        sprite_on = 1'b0;
        tick();

        // Clip in DRAW after 5 pixels
        sprite_datas = desc(14'h0400, 5'd19);
        sprite_on    = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            pixel(1'b1);
            chk_out("clip_pix", 14'(14'h0400 + i), 1'b1, 1'b0);
            tick();
        end
        pixel(1'b0);
        chk_out("clip_edge", 14'h0404, 1'b0, 1'b1);
        tick();
        chk_out("clip_after", 14'h0404, 1'b0, 1'b0);
        pixel(1'b1);
        chk_out("clip_more", 14'h0404, 1'b0, 1'b0);
        sprite_on = 1'b0;
        tick();

        // Wrap with background clamp, strobes back to back
        sprite_datas = desc(14'h3FFA, 5'd7);
        sprite_on    = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            pixel(1'b1);
            chk_out("wrap_pix", wrap_exp[i], 1'b1, (i == 7));
        end
        tick();
        chk_out("wrap_after", 14'h0001, 1'b0, 1'b0);
        sprite_on = 1'b0;
        tick();

        // Abort mid-DRAW
        sprite_datas = desc(14'h0800, 5'd9);
        sprite_on    = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            pixel(1'b1);
            tick();
        end
        sprite_on = 1'b0;
        tick();
        chk_out("abort", 14'h0802, 1'b0, 1'b0);
        chk_bit("abort.busy", busy, 1'b0);
        pixel(1'b1);
        chk_out("abort_pix", 14'h0802, 1'b0, 1'b0);

        // Asynchronous reset mid-DRAW, right after an issued address
        sprite_datas = desc(14'h1000, 5'd9);
        sprite_on    = 1'b1;
        tick();
        pixel(1'b1);
        tick();
        pixel(1'b1);
        chk_out("rst_pre", 14'h1001, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk_out("rst_async", 14'h0000, 1'b0, 1'b0);
        chk_bit("rst_async.busy", busy, 1'b0);
        sprite_on = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk_bit("rst_rel.busy", busy, 1'b0);
        sprite_datas = desc(14'h1234, 5'd2);
        sprite_on    = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            pixel(1'b1);
            chk_out("post_rst_pix", 14'(14'h1234 + i), 1'b1, (i == 2));
            tick();
        end
        sprite_on = 1'b0;
        tick();
        chk_out("b2b_fall", 14'h1236, 1'b0, 1'b0);
        chk_bit("b2b_fall.busy", busy, 1'b0);

        // Back-to-back: new request two clks after the previous fall
        tick();
        sprite_datas = desc(14'h2000, 5'd1);
        sprite_on    = 1'b1;
        tick();
        chk_out("b2b_load", 14'h1236, 1'b0, 1'b0);
        chk_bit("b2b_load.busy", busy, 1'b1);
        pixel(1'b1);
        chk_out("b2b_pix0", 14'h2000, 1'b1, 1'b0);
        tick();
        pixel(1'b1);
        chk_out("b2b_pix1", 14'h2001, 1'b1, 1'b1);
        tick();
        chk_out("b2b_after", 14'h2001, 1'b0, 1'b0);
        sprite_on = 1'b0;
        tick();
        chk_bit("b2b_idle.busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sprite_line_drawer
